// File: rtl/tmnt_pkg.sv
// Shared constants, the per-voice state record and a priority-encode helper
// for the polyphony voice allocator.
package tmnt_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int AGE_W      = $clog2(NUM_VOICES) + 1;
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int AGE_MAX    = (1 << AGE_W) - 1;

  // State kept for each oscillator voice.
  typedef struct packed {
    logic             active;
    logic [KEY_W-1:0] key;
    logic [AGE_W-1:0] age;
  } voice_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector, so callers
  // qualify the result with a reduction-OR of the same vector.
  function automatic logic [KEY_W-1:0] lsb_index(input logic [NUM_KEYS-1:0] vec);
    lsb_index = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) lsb_index = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Synchronizes the raw pushbuttons, detects press/release edges and keeps
// them in sticky pending registers until the allocator services them.
module key_event_detect
  import tmnt_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] pb_i,
  input  logic                enable_i,
  input  logic [NUM_KEYS-1:0] svc_press_i,
  input  logic [NUM_KEYS-1:0] svc_release_i,
  output logic [NUM_KEYS-1:0] pend_press_o,
  output logic [NUM_KEYS-1:0] pend_release_o,
  output logic [NUM_KEYS-1:0] sync_o
);

  logic [NUM_KEYS-1:0] meta_q, sync_q, prev_q;
  logic [NUM_KEYS-1:0] pend_press_q, pend_press_d;
  logic [NUM_KEYS-1:0] pend_release_q, pend_release_d;
  logic [NUM_KEYS-1:0] press_edge, release_edge;

  // Edge detect and pending update; a new edge on a key being serviced this
  // cycle survives because the OR is applied after the service mask.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch so no
    // path can leave it unassigned and infer a latch.
    press_edge     = sync_q & ~prev_q;
    release_edge   = ~sync_q & prev_q;
    pend_press_d   = '0;
    pend_release_d = '0;
    if (enable_i) begin
      pend_press_d   = (pend_press_q & ~svc_press_i) | press_edge;
      pend_release_d = (pend_release_q & ~svc_release_i) | release_edge;
    end
  end

  // Synchronizer, previous-level and pending registers; the synchronizer and
  // prev keep tracking while disabled so no stale edges appear on re-enable.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!nrst) begin
      meta_q         <= '0;
      sync_q         <= '0;
      prev_q         <= '0;
      pend_press_q   <= '0;
      pend_release_q <= '0;
    end else begin
      meta_q         <= pb_i;
      sync_q         <= meta_q;
      prev_q         <= sync_q;
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
    end
  end

  assign pend_press_o   = pend_press_q;
  assign pend_release_o = pend_release_q;
  assign sync_o         = sync_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: services one pending key event per clock, assigning
// presses to free voices (or stealing the oldest) and freeing on release.
module voice_allocator
  import tmnt_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_KEYS-1:0]         pb,
  input  logic                        enable,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        steal_evt,
  output logic                        busy
);

  logic [NUM_KEYS-1:0]   sync, pend_press, pend_release;
  logic [NUM_KEYS-1:0]   svc_press, svc_release;
  voice_t                voices_q [NUM_VOICES];
  voice_t                voices_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  steal_q, steal_d;
  logic [KEY_W-1:0]      rel_key, press_key;
  logic [NUM_VOICES-1:0] free_mask;
  logic [VOICE_W-1:0]    free_idx, old_idx, alloc_idx;
  logic [AGE_W-1:0]      old_age;

  key_event_detect u_key_event_detect (
    .clk            (clk),
    .nrst           (nrst),
    .pb_i           (pb),
    .enable_i       (enable),
    .svc_press_i    (svc_press),
    .svc_release_i  (svc_release),
    .pend_press_o   (pend_press),
    .pend_release_o (pend_release),
    .sync_o         (sync)
  );

  // Arbitration (releases before presses, lowest key first) and voice update.
  always_comb begin
    voices_d    = voices_q;
    trig_d      = '0;
    steal_d     = 1'b0;
    svc_press   = '0;
    svc_release = '0;
    rel_key     = lsb_index(pend_release);
    press_key   = lsb_index(pend_press);
    for (int v = 0; v < NUM_VOICES; v++) free_mask[v] = ~voices_q[v].active;
    free_idx = VOICE_W'(lsb_index(NUM_KEYS'(free_mask)));
    old_idx  = '0;
    old_age  = voices_q[0].age;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (voices_q[v].age > old_age) begin
        old_idx = VOICE_W'(v);
        old_age = voices_q[v].age;
      end
    end
    alloc_idx = (|free_mask) ? free_idx : old_idx;

    if (!enable) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        voices_d[v].active = 1'b0;
        voices_d[v].age    = '0;
      end
    end else if (|pend_release) begin
      svc_release = NUM_KEYS'(1) << rel_key;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voices_q[v].active && voices_q[v].key == rel_key) voices_d[v].active = 1'b0;
      end
    end else if (|pend_press) begin
      svc_press = NUM_KEYS'(1) << press_key;
      // A key already released by the time it is serviced is discarded.
      if (sync[press_key]) begin
        steal_d = ~(|free_mask);
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VOICE_W'(v) == alloc_idx) begin
            voices_d[v].active = 1'b1;
            voices_d[v].key    = press_key;
            voices_d[v].age    = '0;
            trig_d[v]          = 1'b1;
          end else if (voices_q[v].active && voices_q[v].age != AGE_W'(AGE_MAX)) begin
            voices_d[v].age = voices_q[v].age + AGE_W'(1);
          end
        end
      end
    end
  end

  // Voice array and pulse output registers.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: the voice array is a handful of flops, not RAM, so it is cleared
    // by reset like any other state register.
    if (!nrst) begin
      for (int v = 0; v < NUM_VOICES; v++) voices_q[v] <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
    end else begin
      voices_q <= voices_d;
      trig_q   <= trig_d;
      steal_q  <= steal_d;
    end
  end

  // Flatten the voice records onto the output buses.
  always_comb begin
    voice_active = '0;
    voice_key    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_active[v]              = voices_q[v].active;
      voice_key[v*KEY_W +: KEY_W]  = voices_q[v].key;
    end
  end

  assign voice_trig = trig_q;
  assign steal_evt  = steal_q;
  assign busy       = (|pend_press) | (|pend_release);

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// key activity, compared every cycle against a behavioural model.
module tb_voice_allocator;
  import tmnt_pkg::*;

  logic                        clk = 1'b0;
  logic                        nrst;
  logic [NUM_KEYS-1:0]         pb;
  logic                        enable;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_trig;
  logic                        steal_evt;
  logic                        busy;

  int n_cmp = 0;
  int n_bad = 0;

  voice_allocator dut (
    .clk          (clk),
    .nrst         (nrst),
    .pb           (pb),
    .enable       (enable),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_trig   (voice_trig),
    .steal_evt    (steal_evt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pb samples taken at the last three edges, pending
  // event sets, and voices whose age is the number of allocations since
  // they were assigned (saturated).
  bit [NUM_KEYS-1:0] m_hist [3];
  bit [NUM_KEYS-1:0] m_pp, m_pr;
  bit                m_act   [NUM_VOICES];
  int                m_key   [NUM_VOICES];
  int                m_stamp [NUM_VOICES];
  int                m_allocs;
  bit [NUM_VOICES-1:0] m_trig;
  bit                m_steal;

  function automatic int lowest(input bit [NUM_KEYS-1:0] v);
    for (int i = 0; i < NUM_KEYS; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int m_age(input int v);
    int a;
    a = m_allocs - m_stamp[v];
    return (a > AGE_MAX) ? AGE_MAX : a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_pp = '0; m_pr = '0; m_trig = '0; m_steal = 1'b0; m_allocs = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      m_act[v] = 1'b0; m_key[v] = 0; m_stamp[v] = 0;
    end
  endtask

  task automatic model_alloc(input int k);
    int v, best;
    v = -1;
    for (int i = 0; i < NUM_VOICES; i++) if (!m_act[i] && v < 0) v = i;
    if (v < 0) begin
      best = 0;
      for (int i = 1; i < NUM_VOICES; i++) if (m_age(i) > m_age(best)) best = i;
      v = best;
      m_steal = 1'b1;
    end
    m_allocs++;
    m_act[v] = 1'b1; m_key[v] = k; m_stamp[v] = m_allocs; m_trig[v] = 1'b1;
  endtask

  task automatic model_step();
    bit [NUM_KEYS-1:0] sync, prev, svc_p, svc_r;
    int k;
    sync = m_hist[1];
    prev = m_hist[2];
    m_trig = '0; m_steal = 1'b0;
    if (!enable) begin
      for (int v = 0; v < NUM_VOICES; v++) m_act[v] = 1'b0;
      m_pp = '0; m_pr = '0;
    end else begin
      svc_p = '0; svc_r = '0;
      k = lowest(m_pr);
      if (k >= 0) begin
        svc_r[k] = 1'b1;
        for (int v = 0; v < NUM_VOICES; v++) if (m_act[v] && m_key[v] == k) m_act[v] = 1'b0;
      end else begin
        k = lowest(m_pp);
        if (k >= 0) begin
          svc_p[k] = 1'b1;
          if (sync[k]) model_alloc(k);
        end
      end
      m_pp = (m_pp & ~svc_p) | (sync & ~prev);
      m_pr = (m_pr & ~svc_r) | (~sync & prev);
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pb;
  endtask

  always @(posedge clk) if (nrst) model_step();

  // Cycle-by-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NUM_VOICES-1:0]       e_act;
    logic [NUM_VOICES*KEY_W-1:0] e_key;
    for (int v = 0; v < NUM_VOICES; v++) begin
      e_act[v] = m_act[v];
      e_key[v*KEY_W +: KEY_W] = KEY_W'(m_key[v]);
    end
    check("m_active", voice_active, e_act);
    check("m_key", voice_key, e_key);
    check("m_trig", voice_trig, m_trig);
    check("m_steal", steal_evt, m_steal);
    check("m_busy", busy, (m_pp != 0) || (m_pr != 0));
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; enable = 1'b1; pb = '0;
    model_reset();
    wait_edges(3);
    nrst = 1'b1;
    wait_edges(2);
    check("rst_active", voice_active, 0);
    check("rst_busy", busy, 0);

    // Single note on key 5.
    pb[5] = 1'b1;
    wait_edges(3);
    check("note_e3_active", voice_active, 0);
    wait_edges(1);
    check("note_active", voice_active, 4'b0001);
    check("note_key", voice_key[3:0], 5);
    check("note_trig", voice_trig, 4'b0001);
    wait_edges(1);
    check("note_trig_off", voice_trig, 0);
    pb[5] = 1'b0;
    wait_edges(4);
    check("note_release", voice_active, 0);

    // Chord of keys 1..4.
    pb = 16'h001E;
    wait_edges(3);
    check("chord_busy_e3", busy, 1);
    wait_edges(1);
    check("chord_e4_active", voice_active, 4'b0001);
    check("chord_e4_key", voice_key[3:0], 1);
    check("chord_e4_trig", voice_trig, 4'b0001);
    wait_edges(2);
    check("chord_busy_e6", busy, 1);
    wait_edges(1);
    check("chord_active", voice_active, 4'b1111);
    check("chord_keys", voice_key, 16'h4321);
    check("chord_e7_trig", voice_trig, 4'b1000);
    check("chord_busy_e7", busy, 0);

    // Steal the oldest voice with key 9.
    pb[9] = 1'b1;
    wait_edges(4);
    check("steal_key", voice_key, 16'h4329);
    check("steal_evt", steal_evt, 1);
    check("steal_trig", voice_trig, 4'b0001);
    wait_edges(1);
    check("steal_evt_off", steal_evt, 0);

    // Release of 2 ahead of a short pulse on key 7.
    pb[2] = 1'b0; pb[7] = 1'b1;
    wait_edges(1);
    pb[7] = 1'b0;
    wait_edges(3);
    check("order_rel2", voice_active, 4'b1101);
    wait_edges(2);
    check("order_active", voice_active, 4'b1101);
    check("order_busy", busy, 0);
    check("order_trig", voice_trig, 0);

    // Enable drop for one edge; held keys do not re-sound.
    enable = 1'b0;
    wait_edges(1);
    enable = 1'b1;
    check("en_active", voice_active, 0);
    check("en_busy", busy, 0);
    check("en_trig", voice_trig, 0);
    wait_edges(6);
    check("en_held_silent", voice_active, 0);
    pb[3] = 1'b0;
    wait_edges(3);
    pb[3] = 1'b1;
    wait_edges(3);
    check("en_repress_e3", voice_active, 0);
    wait_edges(1);
    check("en_repress_active", voice_active, 4'b0001);
    check("en_repress_key", voice_key[3:0], 3);

    // Asynchronous reset in the middle of a chord.
    pb = 16'h001E;
    wait_edges(5);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    check("arst_active", voice_active, 0);
    check("arst_key", voice_key, 0);
    check("arst_trig", voice_trig, 0);
    check("arst_steal", steal_evt, 0);
    check("arst_busy", busy, 0);
    pb = 16'h0001;
    wait_edges(2);
    nrst = 1'b1;
    wait_edges(3);
    check("arst_e3_active", voice_active, 0);
    wait_edges(1);
    check("arst_note_active", voice_active, 4'b0001);
    check("arst_note_key", voice_key[3:0], 0);
    check("arst_note_trig", voice_trig, 4'b0001);

    // Random key activity with occasional enable drops.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) pb[$urandom_range(0, NUM_KEYS - 1)] ^= 1'b1;
    end
    pb = '0;
    wait_edges(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
